mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: MAC operand width; passed through to the array.
REQ-002 SHALL have parameter DIM, default 8: number of MAC rows in the array, and vector length.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 SHALL have port a_empty, input, DIM bits: per-row A FIFO empty flags.
REQ-007 SHALL have port b_empty, input, 1 bit: B vector FIFO empty flag.
REQ-008 SHALL have port a_rden, output, DIM bits: per-row A FIFO read strobes.
REQ-009 SHALL have port b_rden, output, 1 bit: B FIFO read strobe.
REQ-010 SHALL have port mac_clr, output, 1 bit: Clr for all MAC rows.
REQ-011 SHALL have port mac_en, output, DIM bits: per-row MAC En.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-014 SHALL have port res_valid, output, 1 bit: high while res_row selects a valid result.
REQ-015 SHALL have port res_row, output, $clog2(DIM) bits: index of the result row being read out.
REQ-016 SHALL have port perf_stall_cnt, output, 16 bits: count of stall cycles in the current job.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, RUN, DRAIN and READOUT.
REQ-018 SHALL move IDLE->CLEAR when start=1; CLEAR lasts 1 cycle, with mac_clr=1 only in this state.
REQ-019 SHALL in RUN hold step counter s, running 0..2*DIM-2; row r is active at step s iff r <= s < r+DIM.
REQ-020 SHALL treat step s as ready iff every active row has a_empty[r]=0 and, when s < DIM, b_empty=0.
REQ-021 SHALL on a ready step assert a_rden[r] for each active row and b_rden when s < DIM, then increment s.
REQ-022 SHALL on a not-ready step (stall) drive all rden outputs to 0 and hold s; no partial reads are allowed.
REQ-023 SHALL drive mac_en[r] as a_rden[r] registered by one cycle, matching the 1-cycle FIFO read latency.
REQ-024 SHALL leave RUN for DRAIN after the ready step s=2*DIM-2; DRAIN lasts 1 cycle so the final mac_en lands.
REQ-025 SHALL in READOUT assert res_valid for DIM consecutive cycles, with res_row = 0..DIM-1 in order.
REQ-026 SHALL pulse done=1 for 1 cycle after the last READOUT cycle, in the same cycle the state returns to IDLE.
REQ-027 SHALL ignore start outside IDLE, with no queuing of the request.
REQ-028 SHALL never assert b_rden more than DIM times, nor a_rden[r] more than DIM times, per job.
REQ-029 SHALL hold res_row at 0 whenever res_valid=0.

Reset
REQ-030 SHALL on rst_n=0 go immediately to IDLE, clear s, res_row and the pipeline registers, and drive every output to 0, including mid-job.
REQ-031 SHALL NOT assert mac_clr on reset; the MAC rows have their own reset.

Configuration
REQ-032 SHALL, with MAC_SEQ_PERF_EN defined, let perf_stall_cnt count RUN stall cycles, saturating at 16'hFFFF, cleared on the IDLE->CLEAR transition, and held after done.
REQ-033 SHALL, with MAC_SEQ_PERF_EN not defined, tie perf_stall_cnt to 0 and infer no counter logic.

Structure
REQ-034 SHALL place the state enum and the DIM and DATA_WIDTH defaults in shared package mac_pkg.
REQ-035 SHALL place the stall counter in sub-module mac_perf_cnt, instantiated only under MAC_SEQ_PERF_EN.

Verification (DIM=8; start sampled high at cycle 0)
REQ-036 SHALL test a job with no stalls: mac_clr at cycle 1; RUN cycles 2-16 with b_rden in 2-9 and a_rden[7] in 9-16; DRAIN at 17; res_valid in 18-25 with res_row 0..7; done at 26; busy 1-25.
REQ-037 SHALL test a stall: b_empty=1 during cycles 4-6 -> rden all 0 in 4-6, s holds at 2, done at 29, perf_stall_cnt=3 (0 without the macro).
REQ-038 SHALL test start while busy: a start pulse at cycle 10 -> no effect, done at 26, and exactly one job.
REQ-039 SHALL test reset mid-job: rst_n=0 at cycle 12 -> all outputs 0 that cycle; after release, start at cycle 20 runs a full job ending with done at cycle 46.
REQ-040 SHALL test a per-row empty: a_empty[7]=1 while step s=14 is due -> a single stall, then s=14 completes with a_rden[7] only.
REQ-041 SHALL test the counts via a scoreboard: the total number of a_rden pulses per row, and of mac_en pulses per row, each equal 8.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the MAC array sequencer.
//   DATA_WIDTH_DEF : default MAC operand width
//   DIM_DEF        : default array dimension (rows, vector length)
//   state_t        : sequencer state encoding
package mac_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DIM_DEF        = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    READOUT = 3'd4
  } state_t;
endpackage

// File: rtl/mac_perf_cnt.sv
// mac_perf_cnt -- saturating 16-bit stall counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (new job accepted), wins over inc
//   inc        : count one stall cycle
//   cnt        : current count, sticks at 16'hFFFF
module mac_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && cnt != 16'hFFFF)   cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- systolic-style sequencer for a DIM-row MAC array.
// Feeds row r from its A FIFO during steps r..r+DIM-1 and the shared B
// FIFO during steps 0..DIM-1; any missing operand stalls the whole step.
// Optional build macro: MAC_SEQ_PERF_EN enables the stall counter.
//   clk, rst_n     : clock, async active-low reset
//   start          : job request (IDLE only)
//   a_empty/b_empty: FIFO empty flags
//   a_rden/b_rden  : FIFO read strobes
//   mac_clr/mac_en : MAC array clear and per-row enables
//   busy, done     : job status
//   res_valid/row  : result row readout
//   perf_stall_cnt : stall cycles in current job (0 if perf disabled)
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM        = DIM_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIM-1:0]         a_empty,
  input  logic                   b_empty,
  output logic [DIM-1:0]         a_rden,
  output logic                   b_rden,
  output logic                   mac_clr,
  output logic [DIM-1:0]         mac_en,
  output logic                   busy,
  output logic                   done,
  output logic                   res_valid,
  output logic [$clog2(DIM)-1:0] res_row,
  output logic [15:0]            perf_stall_cnt
);
  localparam int SW = $clog2(2*DIM);
  localparam int RW = $clog2(DIM);
  localparam logic [SW-1:0] S_LAST   = SW'(2*DIM-2);
  localparam logic [SW-1:0] S_BEND   = SW'(DIM);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);

  // Operand width only matters to the array itself.
  logic dw_unused;
  assign dw_unused = (DATA_WIDTH > 0);

  state_t          state, state_nxt;
  logic [SW-1:0]   s;
  logic [DIM-1:0]  active;
  logic            b_phase, ready, step;

  // Row r consumes operands on the diagonal window r <= s < r+DIM.
  always_comb begin
    active = '0;
    for (int r = 0; r < DIM; r++)
      active[r] = (s >= SW'(r)) && ({1'b0, s} < (SW+1)'(r + DIM));
  end

  assign b_phase = (s < S_BEND);
  // All-or-nothing: one empty operand among the active set stalls every read.
  assign ready   = ((a_empty & active) == '0) && !(b_phase && b_empty);
  assign step    = (state == RUN) && ready;

  assign a_rden    = step ? active : '0;
  assign b_rden    = step && b_phase;
  assign busy      = (state != IDLE);
  assign mac_clr   = (state == CLEAR);
  assign res_valid = (state == READOUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (step && s == S_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = READOUT;
      READOUT: if (res_row == ROW_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      res_row <= '0;
      mac_en  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      s       <= (state == RUN) ? (step ? s + SW'(1) : s) : '0;
      res_row <= (state == READOUT && res_row != ROW_LAST) ? res_row + RW'(1) : '0;
      // FIFO data arrives one cycle after the read strobe.
      mac_en  <= a_rden;
      done    <= (state == READOUT) && (res_row == ROW_LAST);
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic perf_clr, perf_inc;
  assign perf_clr = (state == IDLE) && start;
  assign perf_inc = (state == RUN) && !ready;

  mac_perf_cnt u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (perf_inc),
    .cnt   (perf_stall_cnt)
  );
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl -- scenario bench for mac_seq_ctrl at DIM=8.
// Cycle c of a scenario is the clock period in which the task's loop
// index is c; start high in cycle 0 is sampled at the end of cycle 0.
module tb_mac_seq_ctrl;
  import mac_pkg::*;
  localparam int DIM = 8;
`ifdef MAC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, b_empty = 1'b0;
  logic [DIM-1:0] a_empty = '0;
  logic [DIM-1:0] a_rden, mac_en;
  logic           b_rden, mac_clr, busy, done, res_valid;
  logic [2:0]     res_row;
  logic [15:0]    perf_stall_cnt;

  int vec = 0, err = 0;

  typedef struct { int done_cyc; int per_row; } exp_t;
  exp_t sb[$];

  int a_cnt[DIM] = '{default: 0};
  int e_cnt[DIM] = '{default: 0};

  mac_seq_ctrl #(.DATA_WIDTH(8), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_empty(a_empty), .b_empty(b_empty),
    .a_rden(a_rden), .b_rden(b_rden), .mac_clr(mac_clr), .mac_en(mac_en),
    .busy(busy), .done(done), .res_valid(res_valid), .res_row(res_row),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled at the active edge.
  always @(posedge clk) begin
    for (int r = 0; r < DIM; r++) begin
      a_cnt[r] <= a_cnt[r] + int'(a_rden[r]);
      e_cnt[r] <= e_cnt[r] + int'(mac_en[r]);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    vec++; if (a_rden !== '0)    begin err++; $display("FAIL reset a_rden got %h exp 00", a_rden); end
    vec++; if (b_rden !== 1'b0)  begin err++; $display("FAIL reset b_rden got %b exp 0", b_rden); end
    vec++; if (mac_clr !== 1'b0) begin err++; $display("FAIL reset mac_clr got %b exp 0", mac_clr); end
    vec++; if (mac_en !== '0)    begin err++; $display("FAIL reset mac_en got %h exp 00", mac_en); end
    vec++; if (busy !== 1'b0)    begin err++; $display("FAIL reset busy got %b exp 0", busy); end
    vec++; if (done !== 1'b0)    begin err++; $display("FAIL reset done got %b exp 0", done); end
    vec++; if (res_valid !== 1'b0) begin err++; $display("FAIL reset res_valid got %b exp 0", res_valid); end
    vec++; if (res_row !== 3'd0) begin err++; $display("FAIL reset res_row got %0d exp 0", res_row); end
    vec++; if (perf_stall_cnt !== 16'd0) begin err++; $display("FAIL reset perf got %0d exp 0", perf_stall_cnt); end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_release busy got %b exp 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_no_stall();
    exp_t e; int a0[DIM]; int e0[DIM]; logic [2:0] er;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0);
      if (c == 0) begin a0 = a_cnt; e0 = e_cnt; e.done_cyc = 26; e.per_row = DIM; sb.push_back(e); end
      #1;
      er = (c >= 18 && c <= 25) ? 3'(c - 18) : 3'd0;
      vec++; if (mac_clr !== (c == 1)) begin err++; $display("FAIL no_stall mac_clr c=%0d got %b", c, mac_clr); end
      vec++; if (b_rden !== (c >= 2 && c <= 9)) begin err++; $display("FAIL no_stall b_rden c=%0d got %b", c, b_rden); end
      vec++; if (a_rden[0] !== (c >= 2 && c <= 9)) begin err++; $display("FAIL no_stall a_rden0 c=%0d got %b", c, a_rden[0]); end
      vec++; if (a_rden[7] !== (c >= 9 && c <= 16)) begin err++; $display("FAIL no_stall a_rden7 c=%0d got %b", c, a_rden[7]); end
      vec++; if (mac_en[7] !== (c >= 10 && c <= 17)) begin err++; $display("FAIL no_stall mac_en7 c=%0d got %b", c, mac_en[7]); end
      vec++; if (busy !== (c >= 1 && c <= 25)) begin err++; $display("FAIL no_stall busy c=%0d got %b", c, busy); end
      vec++; if (res_valid !== (c >= 18 && c <= 25)) begin err++; $display("FAIL no_stall res_valid c=%0d got %b", c, res_valid); end
      vec++; if (res_row !== er) begin err++; $display("FAIL no_stall res_row c=%0d got %0d exp %0d", c, res_row, er); end
      vec++; if (done !== (c == 26)) begin err++; $display("FAIL no_stall done c=%0d got %b", c, done); end
      if (done === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        for (int r = 0; r < DIM; r++) begin
          vec++; if (a_cnt[r] - a0[r] != e.per_row) begin err++; $display("FAIL no_stall a_rden_count row%0d got %0d exp %0d", r, a_cnt[r] - a0[r], e.per_row); end
          vec++; if (e_cnt[r] - e0[r] != e.per_row) begin err++; $display("FAIL no_stall mac_en_count row%0d got %0d exp %0d", r, e_cnt[r] - e0[r], e.per_row); end
        end
      end
      @(negedge clk);
    end
    vec++; if (sb.size() != 0) begin err++; $display("FAIL no_stall done_timeout pending %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stall();
    exp_t e; int a0[DIM]; int e0[DIM]; logic [15:0] ep;
    ep = PERF ? 16'd3 : 16'd0;
    for (int c = 0; c <= 33; c++) begin
      start = (c == 0);
      b_empty = (c >= 4 && c <= 6);
      if (c == 0) begin a0 = a_cnt; e0 = e_cnt; e.done_cyc = 29; e.per_row = DIM; sb.push_back(e); end
      #1;
      if (c >= 4 && c <= 6) begin
        vec++; if (a_rden !== '0) begin err++; $display("FAIL stall a_rden c=%0d got %h exp 00", c, a_rden); end
      end
      if (c == 3) begin vec++; if (a_rden !== 8'h03) begin err++; $display("FAIL stall a_rden_s1 got %h exp 03", a_rden); end end
      if (c == 7) begin vec++; if (a_rden !== 8'h07) begin err++; $display("FAIL stall a_rden_s2 got %h exp 07", a_rden); end end
      vec++; if (b_rden !== ((c >= 2 && c <= 3) || (c >= 7 && c <= 12))) begin err++; $display("FAIL stall b_rden c=%0d got %b", c, b_rden); end
      vec++; if (done !== (c == 29)) begin err++; $display("FAIL stall done c=%0d got %b", c, done); end
      if (c == 8 || c == 29 || c == 33) begin
        vec++; if (perf_stall_cnt !== ep) begin err++; $display("FAIL stall perf c=%0d got %0d exp %0d", c, perf_stall_cnt, ep); end
      end
      if (done === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        for (int r = 0; r < DIM; r++) begin
          vec++; if (a_cnt[r] - a0[r] != e.per_row) begin err++; $display("FAIL stall a_rden_count row%0d got %0d exp %0d", r, a_cnt[r] - a0[r], e.per_row); end
          vec++; if (e_cnt[r] - e0[r] != e.per_row) begin err++; $display("FAIL stall mac_en_count row%0d got %0d exp %0d", r, e_cnt[r] - e0[r], e.per_row); end
        end
      end
      @(negedge clk);
    end
    vec++; if (sb.size() != 0) begin err++; $display("FAIL stall done_timeout pending %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_start_busy();
    int ndone = 0; int nclr = 0;
    for (int c = 0; c <= 40; c++) begin
      start = (c == 0 || c == 10);
      #1;
      vec++; if (busy !== (c >= 1 && c <= 25)) begin err++; $display("FAIL start_busy busy c=%0d got %b", c, busy); end
      vec++; if (done !== (c == 26)) begin err++; $display("FAIL start_busy done c=%0d got %b", c, done); end
      if (done === 1'b1) ndone++;
      if (mac_clr === 1'b1) nclr++;
      @(negedge clk);
    end
    vec++; if (ndone != 1) begin err++; $display("FAIL start_busy job_count got %0d exp 1", ndone); end
    vec++; if (nclr != 1) begin err++; $display("FAIL start_busy clr_count got %0d exp 1", nclr); end
    vec++; if (perf_stall_cnt !== 16'd0) begin err++; $display("FAIL start_busy perf got %0d exp 0", perf_stall_cnt); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int a0[DIM]; int e0[DIM];
    for (int c = 0; c <= 50; c++) begin
      start = (c == 0 || c == 20);
      if (c == 12) rst_n = 1'b0;
      if (c == 14) rst_n = 1'b1;
      if (c == 20) begin a0 = a_cnt; e0 = e_cnt; e.done_cyc = 46; e.per_row = DIM; sb.push_back(e); end
      #1;
      if (c == 12) begin
        vec++; if ({a_rden, b_rden, mac_clr, mac_en, busy, done, res_valid, res_row, perf_stall_cnt} !== '0) begin
          err++; $display("FAIL reset_mid outputs a=%h b=%b clr=%b en=%h busy=%b done=%b rv=%b row=%0d perf=%0d exp all 0",
                          a_rden, b_rden, mac_clr, mac_en, busy, done, res_valid, res_row, perf_stall_cnt);
        end
      end
      if (c >= 13 && c <= 20) begin
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_mid idle_busy c=%0d got %b exp 0", c, busy); end
      end
      if (c >= 14) begin
        vec++; if (mac_clr !== (c == 21)) begin err++; $display("FAIL reset_mid mac_clr c=%0d got %b", c, mac_clr); end
        vec++; if (done !== (c == 46)) begin err++; $display("FAIL reset_mid done c=%0d got %b", c, done); end
      end
      if (done === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        for (int r = 0; r < DIM; r++) begin
          vec++; if (a_cnt[r] - a0[r] != e.per_row) begin err++; $display("FAIL reset_mid a_rden_count row%0d got %0d exp %0d", r, a_cnt[r] - a0[r], e.per_row); end
          vec++; if (e_cnt[r] - e0[r] != e.per_row) begin err++; $display("FAIL reset_mid mac_en_count row%0d got %0d exp %0d", r, e_cnt[r] - e0[r], e.per_row); end
        end
      end
      @(negedge clk);
    end
    vec++; if (sb.size() != 0) begin err++; $display("FAIL reset_mid done_timeout pending %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_row_empty();
    exp_t e; int a0[DIM]; int e0[DIM]; logic [15:0] ep;
    ep = PERF ? 16'd1 : 16'd0;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0);
      a_empty = (c == 16) ? 8'h80 : 8'h00;
      if (c == 0) begin a0 = a_cnt; e0 = e_cnt; e.done_cyc = 27; e.per_row = DIM; sb.push_back(e); end
      #1;
      if (c == 15) begin vec++; if (a_rden !== 8'hC0) begin err++; $display("FAIL row_empty a_rden_s13 got %h exp c0", a_rden); end end
      if (c == 16) begin vec++; if ({a_rden, b_rden} !== 9'd0) begin err++; $display("FAIL row_empty stall got a=%h b=%b exp 0", a_rden, b_rden); end end
      if (c == 17) begin vec++; if (a_rden !== 8'h80) begin err++; $display("FAIL row_empty a_rden_s14 got %h exp 80", a_rden); end end
      vec++; if (res_valid !== (c >= 19 && c <= 26)) begin err++; $display("FAIL row_empty res_valid c=%0d got %b", c, res_valid); end
      vec++; if (done !== (c == 27)) begin err++; $display("FAIL row_empty done c=%0d got %b", c, done); end
      if (c == 27) begin vec++; if (perf_stall_cnt !== ep) begin err++; $display("FAIL row_empty perf got %0d exp %0d", perf_stall_cnt, ep); end end
      if (done === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        for (int r = 0; r < DIM; r++) begin
          vec++; if (a_cnt[r] - a0[r] != e.per_row) begin err++; $display("FAIL row_empty a_rden_count row%0d got %0d exp %0d", r, a_cnt[r] - a0[r], e.per_row); end
          vec++; if (e_cnt[r] - e0[r] != e.per_row) begin err++; $display("FAIL row_empty mac_en_count row%0d got %0d exp %0d", r, e_cnt[r] - e0[r], e.per_row); end
        end
      end
      @(negedge clk);
    end
    a_empty = '0;
    vec++; if (sb.size() != 0) begin err++; $display("FAIL row_empty done_timeout pending %0d exp 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_no_stall();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_row_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
